// File: rtl/cpu_thread_ctrl_if.sv
// Thread controller bus: thread bookkeeping inputs and pipeline control outputs.
// The master drives the controller; the slave is the controller itself.
interface cpu_thread_ctrl_if #(
    parameter int N_THREADS   = 4,
    parameter int IADDR_WIDTH = 6
);
    localparam int TW = $clog2(N_THREADS);

    logic [N_THREADS-1:0]   thread_ready;
    logic                   ip_wr;
    logic [TW-1:0]          ip_wr_thread;
    logic [IADDR_WIDTH-1:0] ip_wr_addr;
    logic                   ip_inc;
    logic                   jump;
    logic [IADDR_WIDTH-1:0] jump_addr;
    logic                   yield;
    logic [IADDR_WIDTH-1:0] yield_ip;
    logic                   exec_busy;
    logic                   invalidate;
    logic                   reload;
    logic                   instr_wait;
    logic [TW-1:0]          thread_num;
    logic [IADDR_WIDTH-1:0] ip_curr;

    modport master (
        output thread_ready, ip_wr, ip_wr_thread, ip_wr_addr, ip_inc,
               jump, jump_addr, yield, yield_ip, exec_busy,
        input  invalidate, reload, instr_wait, thread_num, ip_curr
    );

    modport slave (
        input  thread_ready, ip_wr, ip_wr_thread, ip_wr_addr, ip_inc,
               jump, jump_addr, yield, yield_ip, exec_busy,
        output invalidate, reload, instr_wait, thread_num, ip_curr
    );
endinterface

// File: rtl/cpu_thread_ctrl.sv
// Round-robin hardware thread scheduler: owns the per-thread IP table and
// drives fetch IP plus flush/reload/freeze controls for the pipeline.
module cpu_thread_ctrl #(
    parameter int N_THREADS   = 4,
    parameter int IADDR_WIDTH = 6
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    cpu_thread_ctrl_if.slave bus
);
    localparam int TW = $clog2(N_THREADS);

    typedef enum logic [2:0] {IDLE, SELECT, RELOAD, RUN, JUMP} state_t;

    state_t                                  r_state, w_next;
    logic                                    r_invalidate, r_reload;
    logic [TW-1:0]                           r_thread_num, w_thread_next;
    logic [IADDR_WIDTH-1:0]                  r_ip_curr, w_ip_next;
    logic [TW-1:0]                           r_last, w_last_next;
    logic [N_THREADS-1:0][IADDR_WIDTH-1:0]   r_ip_table;

    logic                                    w_found;
    logic [TW-1:0]                           w_pick, w_idx;
    logic                                    w_save;
    logic [IADDR_WIDTH-1:0]                  w_save_ip;

    // Scan starts just after the last-run thread so it is considered last.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = 1; i <= N_THREADS; i++) begin
            w_idx = r_last + TW'(i);
            if (!w_found && bus.thread_ready[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        w_thread_next = r_thread_num;
        w_ip_next     = r_ip_curr;
        w_last_next   = r_last;
        w_save        = 1'b0;
        w_save_ip     = bus.yield_ip;
        case (r_state)
            IDLE: if (|bus.thread_ready) w_next = SELECT;
            SELECT: begin
                if (w_found) begin
                    w_next        = RELOAD;
                    w_thread_next = w_pick;
                    w_ip_next     = r_ip_table[w_pick];
                end else begin
                    w_next = IDLE;
                end
            end
            RELOAD: w_next = RUN;
            RUN: begin
                if (bus.yield) begin
                    // A jump taken alongside the yield is where the thread resumes.
                    w_save      = 1'b1;
                    w_save_ip   = bus.jump ? bus.jump_addr : bus.yield_ip;
                    w_last_next = r_thread_num;
                    w_next      = SELECT;
                end else if (bus.jump) begin
                    w_ip_next = bus.jump_addr;
                    w_next    = JUMP;
                end else if (bus.ip_inc) begin
                    w_ip_next = r_ip_curr + IADDR_WIDTH'(1);
                end
            end
            JUMP:    w_next = RELOAD;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_invalidate <= 1'b1;
            r_reload     <= 1'b0;
            r_thread_num <= '0;
            r_ip_curr    <= '0;
            r_last       <= TW'(N_THREADS - 1);
        end else begin
            r_state      <= w_next;
            r_invalidate <= (w_next == IDLE) || (w_next == SELECT) || (w_next == JUMP);
            r_reload     <= (w_next == RELOAD);
            r_thread_num <= w_thread_next;
            r_ip_curr    <= w_ip_next;
            r_last       <= w_last_next;
        end
    end

    // Yield save beats an external write to the same entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ip_table <= '0;
        end else begin
            for (int t = 0; t < N_THREADS; t++) begin
                if (w_save && (r_thread_num == TW'(t)))
                    r_ip_table[t] <= w_save_ip;
                else if (bus.ip_wr && (bus.ip_wr_thread == TW'(t)))
                    r_ip_table[t] <= bus.ip_wr_addr;
            end
        end
    end

    assign bus.invalidate = r_invalidate;
    assign bus.reload     = r_reload;
    assign bus.thread_num = r_thread_num;
    assign bus.ip_curr    = r_ip_curr;
    assign bus.instr_wait = (r_state == RUN) && bus.exec_busy;
endmodule

// File: tb/tb_cpu_thread_ctrl.sv
// Directed bench for cpu_thread_ctrl: inputs change and outputs are sampled
// on the falling clock edge, away from the active edge.
module tb_cpu_thread_ctrl;
    localparam int N  = 4;
    localparam int W  = 6;
    localparam int TW = 2;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    cpu_thread_ctrl_if #(.N_THREADS(N), .IADDR_WIDTH(W)) bus ();

    cpu_thread_ctrl #(.N_THREADS(N), .IADDR_WIDTH(W)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.thread_ready = '0; bus.ip_wr = 0; bus.ip_wr_thread = '0; bus.ip_wr_addr = '0;
        bus.ip_inc = 0; bus.jump = 0; bus.jump_addr = '0; bus.yield = 0; bus.yield_ip = '0;
        bus.exec_busy = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (bus.invalidate !== 1'b1) begin bad++; $display("FAIL rst_inv got=%b exp=1", bus.invalidate); end
        total++; if (bus.reload !== 1'b0) begin bad++; $display("FAIL rst_reload got=%b exp=0", bus.reload); end
        total++; if (bus.thread_num !== 2'd0) begin bad++; $display("FAIL rst_tn got=%0d exp=0", bus.thread_num); end
        total++; if (bus.ip_curr !== 6'd0) begin bad++; $display("FAIL rst_ip got=%0d exp=0", bus.ip_curr); end
        total++; if (bus.instr_wait !== 1'b0) begin bad++; $display("FAIL rst_iwait got=%b exp=0", bus.instr_wait); end
        bus.exec_busy = 1'b0;
        rst_n = 1'b1;
        step();
        total++; if (bus.invalidate !== 1'b1 || bus.reload !== 1'b0) begin bad++; $display("FAIL idle_hold inv=%b rel=%b exp 1/0", bus.invalidate, bus.reload); end
    endtask

    task automatic test_select();
        bus.thread_ready = 4'b0001;
        step();
        total++; if (bus.invalidate !== 1'b1 || bus.reload !== 1'b0) begin bad++; $display("FAIL sel_ctrl inv=%b rel=%b exp 1/0", bus.invalidate, bus.reload); end
        step();
        total++; if (bus.reload !== 1'b1 || bus.invalidate !== 1'b0) begin bad++; $display("FAIL reload_ctrl inv=%b rel=%b exp 0/1", bus.invalidate, bus.reload); end
        total++; if (bus.thread_num !== 2'd0 || bus.ip_curr !== 6'd0) begin bad++; $display("FAIL reload_tn_ip tn=%0d ip=%0d exp 0/0", bus.thread_num, bus.ip_curr); end
        bus.exec_busy = 1'b1; #1;
        total++; if (bus.instr_wait !== 1'b0) begin bad++; $display("FAIL iwait_reload got=%b exp=0", bus.instr_wait); end
        bus.exec_busy = 1'b0;
        step();
        total++; if (bus.reload !== 1'b0 || bus.invalidate !== 1'b0) begin bad++; $display("FAIL run_ctrl inv=%b rel=%b exp 0/0", bus.invalidate, bus.reload); end
        bus.exec_busy = 1'b1; #1;
        total++; if (bus.instr_wait !== 1'b1) begin bad++; $display("FAIL iwait_run got=%b exp=1", bus.instr_wait); end
        bus.exec_busy = 1'b0;
    endtask

    task automatic test_inc();
        bus.ip_inc = 1'b1;
        repeat (5) step();
        bus.ip_inc = 1'b0;
        total++; if (bus.ip_curr !== 6'd5) begin bad++; $display("FAIL inc5 got=%0d exp=5", bus.ip_curr); end
        step();
        total++; if (bus.ip_curr !== 6'd5) begin bad++; $display("FAIL inc_hold got=%0d exp=5", bus.ip_curr); end
        bus.ip_inc = 1'b1;
        repeat (3) step();
        bus.ip_inc = 1'b0;
        total++; if (bus.ip_curr !== 6'd8) begin bad++; $display("FAIL inc8 got=%0d exp=8", bus.ip_curr); end
    endtask

    task automatic test_jump();
        bus.jump = 1'b1; bus.jump_addr = 6'd20; bus.ip_inc = 1'b1;
        step();
        bus.jump = 1'b0;
        total++; if (bus.invalidate !== 1'b1 || bus.reload !== 1'b0 || bus.ip_curr !== 6'd20) begin bad++; $display("FAIL jump_cyc inv=%b rel=%b ip=%0d exp 1/0/20", bus.invalidate, bus.reload, bus.ip_curr); end
        step();
        bus.ip_inc = 1'b0;
        total++; if (bus.invalidate !== 1'b0 || bus.reload !== 1'b1 || bus.ip_curr !== 6'd20) begin bad++; $display("FAIL jump_reload inv=%b rel=%b ip=%0d exp 0/1/20", bus.invalidate, bus.reload, bus.ip_curr); end
        step();
        total++; if (bus.invalidate !== 1'b0 || bus.reload !== 1'b0 || bus.ip_curr !== 6'd20) begin bad++; $display("FAIL jump_run inv=%b rel=%b ip=%0d exp 0/0/20", bus.invalidate, bus.reload, bus.ip_curr); end
        // wrap 63 -> 0
        bus.jump = 1'b1; bus.jump_addr = 6'd63;
        step();
        bus.jump = 1'b0;
        step(); step();
        total++; if (bus.ip_curr !== 6'd63) begin bad++; $display("FAIL jump63 got=%0d exp=63", bus.ip_curr); end
        bus.ip_inc = 1'b1;
        step();
        bus.ip_inc = 1'b0;
        total++; if (bus.ip_curr !== 6'd0) begin bad++; $display("FAIL wrap got=%0d exp=0", bus.ip_curr); end
    endtask

    task automatic test_yield();
        bus.thread_ready = 4'b0101;
        bus.ip_wr = 1'b1; bus.ip_wr_thread = 2'd2; bus.ip_wr_addr = 6'd17;
        step();
        bus.ip_wr = 1'b0;
        total++; if (bus.ip_curr !== 6'd0 || bus.thread_num !== 2'd0) begin bad++; $display("FAIL ipwr_no_touch tn=%0d ip=%0d exp 0/0", bus.thread_num, bus.ip_curr); end
        bus.thread_ready = 4'b0100;
        step();
        bus.exec_busy = 1'b1; #1;
        total++; if (bus.instr_wait !== 1'b1 || bus.thread_num !== 2'd0) begin bad++; $display("FAIL ready_drop iwait=%b tn=%0d exp 1/0", bus.instr_wait, bus.thread_num); end
        bus.exec_busy = 1'b0;
        bus.thread_ready = 4'b0101;
        bus.yield = 1'b1; bus.yield_ip = 6'd9;
        step();
        bus.yield = 1'b0;
        total++; if (bus.invalidate !== 1'b1 || bus.reload !== 1'b0) begin bad++; $display("FAIL yield_sel inv=%b rel=%b exp 1/0", bus.invalidate, bus.reload); end
        step();
        total++; if (bus.reload !== 1'b1 || bus.thread_num !== 2'd2 || bus.ip_curr !== 6'd17) begin bad++; $display("FAIL yield_t2 rel=%b tn=%0d ip=%0d exp 1/2/17", bus.reload, bus.thread_num, bus.ip_curr); end
        step();
        bus.yield = 1'b1; bus.yield_ip = 6'd40;
        step();
        bus.yield = 1'b0;
        step();
        total++; if (bus.reload !== 1'b1 || bus.thread_num !== 2'd0 || bus.ip_curr !== 6'd9) begin bad++; $display("FAIL resume_t0 rel=%b tn=%0d ip=%0d exp 1/0/9", bus.reload, bus.thread_num, bus.ip_curr); end
        step();
    endtask

    task automatic test_yield_jump();
        bus.thread_ready = 4'b0001;
        bus.yield = 1'b1; bus.yield_ip = 6'd50; bus.jump = 1'b1; bus.jump_addr = 6'd33;
        bus.ip_wr = 1'b1; bus.ip_wr_thread = 2'd0; bus.ip_wr_addr = 6'd44;
        step();
        bus.yield = 1'b0; bus.jump = 1'b0; bus.ip_wr = 1'b0;
        total++; if (bus.invalidate !== 1'b1 || bus.reload !== 1'b0) begin bad++; $display("FAIL yj_sel inv=%b rel=%b exp 1/0", bus.invalidate, bus.reload); end
        step();
        total++; if (bus.thread_num !== 2'd0 || bus.ip_curr !== 6'd33) begin bad++; $display("FAIL yj_saved tn=%0d ip=%0d exp 0/33", bus.thread_num, bus.ip_curr); end
        step();
    endtask

    task automatic test_back_to_idle();
        bus.thread_ready = 4'b0000;
        bus.yield = 1'b1; bus.yield_ip = 6'd12;
        step();
        bus.yield = 1'b0;
        step();
        total++; if (bus.invalidate !== 1'b1 || bus.reload !== 1'b0) begin bad++; $display("FAIL empty_sel inv=%b rel=%b exp 1/0", bus.invalidate, bus.reload); end
        bus.ip_inc = 1'b1; bus.jump = 1'b1; bus.jump_addr = 6'd7;
        step();
        bus.ip_inc = 1'b0; bus.jump = 1'b0;
        bus.exec_busy = 1'b1; #1;
        total++; if (bus.instr_wait !== 1'b0 || bus.invalidate !== 1'b1 || bus.ip_curr !== 6'd33) begin bad++; $display("FAIL idle_ignore iwait=%b inv=%b ip=%0d exp 0/1/33", bus.instr_wait, bus.invalidate, bus.ip_curr); end
        bus.exec_busy = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.thread_ready = 4'b0001;
        step(); step();
        total++; if (bus.ip_curr !== 6'd12 || bus.reload !== 1'b1) begin bad++; $display("FAIL pre_rst ip=%0d rel=%b exp 12/1", bus.ip_curr, bus.reload); end
        step();
        bus.thread_ready = 4'b0101;
        bus.exec_busy = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.invalidate !== 1'b1 || bus.reload !== 1'b0 || bus.thread_num !== 2'd0 || bus.ip_curr !== 6'd0 || bus.instr_wait !== 1'b0)
            begin bad++; $display("FAIL async_rst inv=%b rel=%b tn=%0d ip=%0d iw=%b exp 1/0/0/0/0", bus.invalidate, bus.reload, bus.thread_num, bus.ip_curr, bus.instr_wait); end
        bus.exec_busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(); step();
        total++; if (bus.thread_num !== 2'd0 || bus.ip_curr !== 6'd0 || bus.reload !== 1'b1) begin bad++; $display("FAIL post_rst_t0 tn=%0d ip=%0d rel=%b exp 0/0/1", bus.thread_num, bus.ip_curr, bus.reload); end
        step();
        bus.yield = 1'b1; bus.yield_ip = 6'd3;
        step();
        bus.yield = 1'b0;
        step();
        total++; if (bus.thread_num !== 2'd2 || bus.ip_curr !== 6'd0) begin bad++; $display("FAIL table_clr tn=%0d ip=%0d exp 2/0", bus.thread_num, bus.ip_curr); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_select();
        test_inc();
        test_jump();
        test_yield();
        test_yield_jump();
        test_back_to_idle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_thread_ctrl.md
CPU_THREAD_CTRL -- requirements
Module: cpu_thread_ctrl

Interface
REQ-001 Parameter N_THREADS, default 4: number of hardware threads; power of 2, 2..16.
REQ-002 Parameter IADDR_WIDTH, default 6: instruction address width.
REQ-003 CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 thread_ready  input  N_THREADS  per-thread "has work" flags.
REQ-006 ip_wr  input  1  write strobe into the per-thread IP table.
REQ-007 ip_wr_thread  input  log2(N_THREADS)  thread index for ip_wr.
REQ-008 ip_wr_addr  input  IADDR_WIDTH  IP value for ip_wr.
REQ-009 ip_inc  input  1  instruction fetched; connected to the stage-0 allow of the pipeline-state block.
REQ-010 jump  input  1  execution stage takes a jump, 1-cycle pulse.
REQ-011 jump_addr  input  IADDR_WIDTH  jump target.
REQ-012 yield  input  1  running thread gives up the CPU, 1-cycle pulse.
REQ-013 yield_ip  input  IADDR_WIDTH  IP at which the yielding thread resumes.
REQ-014 exec_busy  input  1  execution unit stall request.
REQ-015 invalidate  output  1  flush all pipeline stages.
REQ-016 reload  output  1  IP valid for the pipeline; restart fetch.
REQ-017 instr_wait  output  1  freeze pipeline.
REQ-018 thread_num  output  log2(N_THREADS)  currently selected thread.
REQ-019 ip_curr  output  IADDR_WIDTH  instruction pointer for fetch.

Function
REQ-020 FSM states: IDLE, SELECT, RELOAD, RUN, JUMP; state, invalidate, reload, thread_num and ip_curr are registered.
REQ-021 IDLE: invalidate=1, reload=0; to SELECT on the first cycle thread_ready != 0.
REQ-022 SELECT: round-robin pick of the first ready thread after the last-run thread (wrap N_THREADS-1 -> 0); thread_num <= pick; ip_curr <= ip_table[pick]; invalidate=1; to RELOAD. If no thread is ready in SELECT, go to IDLE.
REQ-023 RELOAD: reload=1 and invalidate=0 for exactly one cycle; then RUN.
REQ-024 RUN: invalidate=0, reload=0; ip_curr increments by 1 (mod 2^IADDR_WIDTH) on each cycle ip_inc=1.
REQ-025 RUN + jump: ip_curr <= jump_addr; invalidate=1 for one cycle (state JUMP); then RELOAD; ip_inc is ignored on that cycle.
REQ-026 RUN + yield: ip_table[thread_num] <= yield_ip; invalidate=1 next cycle; to SELECT; the yielding thread becomes the last-run thread.
REQ-027 yield and jump in the same cycle: yield wins; stored IP = jump_addr.
REQ-028 jump, yield and ip_inc outside RUN are ignored.
REQ-029 instr_wait = exec_busy when state=RUN, else 0 (combinational, same cycle).
REQ-030 instr_wait=1 does not block jump or yield; ip_inc is never asserted while instr_wait=1 (upstream guarantee; not checked).
REQ-031 ip_wr writes ip_table[ip_wr_thread] in any state; it does not alter ip_curr of the running thread.
REQ-032 ip_wr to the running thread in the yield cycle: yield_ip wins.
REQ-033 A ready flag dropping while its thread is in RUN has no effect until that thread yields.

Reset
REQ-034 rst_n low: state=IDLE, invalidate=1, reload=0, thread_num=0, ip_curr=0, all ip_table entries=0, last-run=N_THREADS-1 (thread 0 first).
REQ-035 rst_n asserted mid-operation aborts immediately; no yield save completes; the first cycle after release behaves as IDLE.

Verification
REQ-036 After reset, thread_ready=4'b0001 -> SELECT, then reload=1 with thread_num=0 and ip_curr=0, then RUN.
REQ-037 RUN with ip_inc high for 3 cycles from ip_curr=5 -> ip_curr=8; ip_inc from 63 -> 0 (wrap).
REQ-038 RUN with jump=1 and jump_addr=20 -> invalidate=1 for one cycle, reload=1 with ip_curr=20, back in RUN.
REQ-039 Threads 0 and 2 ready; thread 0 yields with yield_ip=9 -> thread_num=2 is reloaded; thread 2 yields -> thread 0 resumes with ip_curr=9.
REQ-040 Same-cycle yield and jump with jump_addr=33 -> ip_table[thread]=33; exec_busy=1 in RUN -> instr_wait=1; exec_busy=1 in IDLE -> instr_wait=0.
REQ-041 rst_n pulsed low during RUN at ip_curr=12 -> outputs return to reset values asynchronously; ip_table cleared.
